// File: rtl/accumulator_sat.sv
// Purpose: sums the data beats of each eot-terminated transaction, seeded by the offset on the first beat.
// Latency: an eot beat accepted in cycle N presents {ovf, count, acc} on dout in cycle N+1.
// Backpressure: non-eot beats are always taken; an eot beat stalls only while an unconsumed result is blocked.
module accumulator_sat #(
    parameter int W_DATA   = 16,
    parameter int W_ACC    = 24,
    parameter int W_CNT    = 16,
    parameter int SIGNED   = 0,
    parameter int SATURATE = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      din_vld,
    output logic                      din_rdy,
    input  logic [W_ACC+W_DATA:0]     din_dat,
    output logic                      dout_vld,
    input  logic                      dout_rdy,
    output logic [W_CNT+W_ACC:0]      dout_dat
);

    localparam logic [W_ACC-1:0] SMAX = {1'b0, {(W_ACC-1){1'b1}}};
    localparam logic [W_ACC-1:0] SMIN = {1'b1, {(W_ACC-1){1'b0}}};

    // Running transaction state and the decoupled result register.
    logic [W_ACC-1:0]        acc_q, acc_d;
    logic [W_CNT-1:0]        cnt_q, cnt_d;
    logic                    ovf_q, ovf_d;
    logic                    first_q, first_d;
    logic                    out_vld_q, out_vld_d;
    logic [W_CNT+W_ACC:0]    out_dat_q, out_dat_d;

    logic                    din_eot;
    logic [W_ACC-1:0]        din_off;
    logic [W_DATA-1:0]       din_data;
    logic signed [W_DATA-1:0] data_s;
    logic [W_ACC-1:0]        ext;
    logic [W_ACC-1:0]        base;
    logic [W_ACC:0]          sum;
    logic                    step_ovf;
    logic [W_ACC-1:0]        sat_val;
    logic [W_ACC-1:0]        result;
    logic                    din_hs;
    logic                    dout_hs;

    assign din_eot  = din_dat[W_ACC+W_DATA];
    assign din_off  = din_dat[W_ACC+W_DATA-1:W_DATA];
    assign din_data = din_dat[W_DATA-1:0];
    assign data_s   = din_data;

    // A blocked result only holds back the beat that would overwrite it.
    assign din_rdy  = !out_vld_q || dout_rdy || !din_eot;
    assign din_hs   = din_vld && din_rdy;
    assign dout_hs  = out_vld_q && dout_rdy;
    assign dout_vld = out_vld_q;
    assign dout_dat = out_dat_q;

    // One accumulation step: extend, add one bit wide, detect overflow, optionally clamp.
    always_comb begin
        if (SIGNED != 0) begin
            ext = W_ACC'(data_s);
        end else begin
            ext = W_ACC'(din_data);
        end
        base = first_q ? din_off : acc_q;
        sum  = {1'b0, base} + {1'b0, ext};
        if (SIGNED != 0) begin
            step_ovf = (base[W_ACC-1] == ext[W_ACC-1]) && (sum[W_ACC-1] != base[W_ACC-1]);
            sat_val  = base[W_ACC-1] ? SMIN : SMAX;
        end else begin
            step_ovf = sum[W_ACC];
            sat_val  = '1;
        end
        result = ((SATURATE != 0) && step_ovf) ? sat_val : sum[W_ACC-1:0];
    end

    // Next-state: an eot accept in the same cycle as a dout transfer overwrites without a bubble.
    always_comb begin
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        ovf_d     = ovf_q;
        first_d   = first_q;
        out_vld_d = out_vld_q;
        out_dat_d = out_dat_q;
        if (dout_hs) begin
            out_vld_d = 1'b0;
        end
        if (din_hs) begin
            acc_d   = result;
            cnt_d   = first_q ? W_CNT'(1) : ((&cnt_q) ? cnt_q : cnt_q + W_CNT'(1));
            ovf_d   = (!first_q && ovf_q) || step_ovf;
            first_d = din_eot;
            if (din_eot) begin
                out_vld_d = 1'b1;
                out_dat_d = {ovf_d, cnt_d, result};
            end
        end
    end

    // State registers with synchronous reset; reset drops any partial sum and pending result.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q     <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            first_q   <= 1'b1;
            out_vld_q <= 1'b0;
            out_dat_q <= '0;
        end else begin
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
            first_q   <= first_d;
            out_vld_q <= out_vld_d;
            out_dat_q <= out_dat_d;
        end
    end

endmodule

// File: doc/accumulator_sat.md
Name: accumulator_sat

Overview:
- Parametrised successor to the team's eot-terminated stream accumulator.
- Sums every data beat of a transaction, seeded by the offset carried on the first beat.
- Generalisations: separate data and accumulator widths, signed/unsigned mode, saturating or wrapping arithmetic, sticky overflow flag, beat count.
- Running sum and result register are decoupled, so a new transaction can start while the previous result waits on dout.
- Sits between dti producer and consumer stages in cookbook datapaths.

Parameters:
- W_DATA, 16, width of input data field.
- W_ACC, 24, width of offset and accumulator (W_ACC >= W_DATA).
- W_CNT, 16, width of beat counter in the result.
- SIGNED, 0, 1 = data sign-extended and two's-complement arithmetic; 0 = zero-extended, unsigned.
- SATURATE, 0, 1 = clamp on overflow; 0 = wrap modulo 2^W_ACC.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, synchronous, active-high.
- din  dti.consumer  1+W_ACC+W_DATA
  - Packed data, MSB first: {eot, offset[W_ACC], data[W_DATA]}.
- dout  dti.producer  1+W_CNT+W_ACC
  - Packed data, MSB first: {ovf, count[W_CNT], acc[W_ACC]}.

Behaviour:
- Reset, clk and rst: reset rst, synchronous, active-high; clock clk. On reset:
  - acc_r = 0, cnt_r = 0, ovf_r = 0, first_r = 1.
  - out_valid = 0, out_data = 0, so dout.valid = 0.
- Handshakes:
  - din_hs = din.valid & din.ready.
  - dout_hs = dout.valid & dout.ready.
  - dti rules: dout.valid, once high, holds with stable data until dout_hs. din.valid is never waited on by din.ready, except through the eot term below.
- din.ready = !out_valid | dout.ready | !din.eot.
  - Non-eot beats are always accepted.
  - An eot beat stalls only while an unconsumed result is blocked.
- Operand extension: ext(data) is W_DATA to W_ACC, sign-extended if SIGNED, else zero-extended.
- base = first_r ? offset : acc_r. The offset field is ignored on non-first beats.
- Sum is computed W_ACC+1 wide: s = base + ext(data).
  - Unsigned overflow: carry out, s[W_ACC].
  - Signed overflow: operand sign bits equal and result sign differs.
- Result value:
  - SATURATE=1: clamp to max on overflow.
    - Unsigned: all ones, even though carry implies max.
    - Signed: positive overflow gives 0111..1, negative overflow gives 1000..0.
  - SATURATE=0: low W_ACC bits of s.
- Saturation is per-step: subsequent beats continue from the clamped value.
- On din_hs:
  - acc_r <= result.
  - cnt_r <= first_r ? 1 : sat_inc(cnt_r). The count sticks at 2^W_CNT-1.
  - ovf_r <= (first_r ? 0 : ovf_r) | step_ovf.
  - first_r <= din.eot.
- On din_hs with eot:
  - out_data <= {new ovf, new cnt, result}; out_valid <= 1.
  - Latency: eot beat accepted in cycle N gives dout.valid in cycle N+1.
  - Running state is also updated as above and is then discarded by first_r = 1.
- out_valid clears on dout_hs, unless an eot din_hs occurs in the same cycle.
  - Simultaneous dout_hs and eot din_hs: the new result overwrites; out_valid stays 1; no bubble.
- Single-beat transaction (eot on first beat): acc = offset + ext(data), count = 1.
- Reset mid-transaction: partial sum and pending result are discarded; the next beat is treated as first.
- No combinational path from din to dout data. dout.ready reaches din.ready combinationally.

Test Plan:
- Unsigned, defaults, dout.ready=1. Beats (off=100,d=1),(off=x,d=2),(eot,d=3). Expect:
  - dout {ovf=0, cnt=3, acc=106} one cycle after eot.
  - Exactly one dout transfer.
- Back-to-back single-beat eot transactions (off=0,d=5), (off=10,d=7) with dout.ready=1. Expect:
  - Results 5 then 17, count 1 each.
  - din.ready continuously 1; no bubbles.
- Backpressure: dout.ready=0 while result pending. Expect:
  - Next transaction's non-eot beats accepted.
  - Its eot beat stalls (din.ready=0).
  - Releasing dout.ready delivers the old result, then the new one; dout data stable throughout the stall.
- SATURATE=1, unsigned, W_ACC=24. Offset 0xFFFFF0, beats d=0x20 then d=0x1 (eot). Expect:
  - acc=0xFFFFFF, ovf=1.
  - With SATURATE=0: acc=0x000011, ovf=1.
- SIGNED=1, SATURATE=1, W_DATA=16. Offset 0x800005 (near min), beats d=0xFFF0 (-16) then eot d=0x0001. Expect:
  - acc=0x800001, ovf=1.
  - Clamp to 0x800000 on step 1, then +1.
- Assert rst after 2 beats of a 4-beat transaction, and with a result pending on dout. Expect:
  - dout.valid=0 the next cycle.
  - Next transaction (off=3,d=4,eot) yields {0, 1, 7}.
